control_unit: RTL and testbench

Sequencing controller for the multi-cycle register/ALU datapath. It accepts a 25-bit instruction word on a `new_func` pulse and steps a one-hot state machine through up to three execution steps. In each step it drives the register-file in/out enables, the A/G register strobes, the ALU opcode and the immediate-data bus enable. It sits between the instruction source and the datapath, and owns no datapath storage beyond its latched instruction.

---
 rtl/control_unit_pkg.sv | 59 +++++
 rtl/control_unit_reg_decoder.sv | 26 ++
 rtl/control_unit.sv | 151 +++++++++++++++
 tb/tb_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared constants for the control_unit sequencer: opcodes, one-hot states,
// ALU function codes and instruction-register field positions.
package control_unit_pkg;

  // Opcode field values (IR[24:22])
  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_MV   = 3'b010;
  localparam logic [2:0] OPC_MVI  = 3'b011;
  localparam logic [2:0] OPC_AND  = 3'b100;
  localparam logic [2:0] OPC_OR   = 3'b101;

  // ALU function codes driven on op
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Instruction field bit positions
  localparam int IR_OPC_HI = 24;
  localparam int IR_OPC_LO = 22;
  localparam int IR_RX_HI  = 21;
  localparam int IR_RX_LO  = 19;
  localparam int IR_RY_HI  = 18;
  localparam int IR_RY_LO  = 16;
  localparam int IR_IMM_HI = 15;
  localparam int IR_IMM_LO = 0;

  // One-hot sequencer states
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_T1   = 5'b00010,
    S_T2   = 5'b00100,
    S_T3   = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  // Instruction classes: decides which steps run
  typedef enum logic [1:0] {
    C_NOP = 2'b00,
    C_ALU = 2'b01,
    C_MV  = 2'b10,
    C_MVI = 2'b11
  } cls_t;

  // ALU function for an arithmetic/logic opcode
  function automatic logic [1:0] alu_func(input logic [2:0] opc);
    logic [1:0] f;
    case (opc)
      OPC_ADD: f = ALU_ADD;
      OPC_SUB: f = ALU_SUB;
      OPC_AND: f = ALU_AND;
      OPC_OR:  f = ALU_OR;
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/control_unit_reg_decoder.sv
// Register-index decoder: turns a 3-bit register number plus in/out strobes
// into that register's pair of bits in the 16-bit reg_sig enable vector.
module reg_decoder
  import control_unit_pkg::*;
(
  input  logic [2:0]  idx,
  input  logic        en_in,
  input  logic        en_out,
  output logic [15:0] sig
);

  // Place the strobes at bit 2*idx+1 (in) and 2*idx (out)
  always_comb begin
    sig = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (idx == i[2:0]) begin
        sig[2*i+1] = en_in;
        sig[2*i]   = en_out;
      end else begin
        sig[2*i+1] = 1'b0;
        sig[2*i]   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle datapath sequencer. Latches a 25-bit instruction on new_func
// while idle and walks T1..T3/DONE, decoding Moore control strobes from the
// current state and the latched instruction.
// Optional feature macro: CONTROL_UNIT_LOGIC_OPS_EN enables AND/OR
// (opcodes 100/101); without it those opcodes behave as NOP.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] func,
  input  logic        new_func,
  output logic [15:0] reg_sig,
  output logic        A_in,
  output logic        G_in,
  output logic        G_out,
  output logic        data_in,
  output logic [1:0]  op,
  output logic [4:0]  state,
  output logic [15:0] data
);

  state_t      state_r;
  state_t      state_next_s;
  logic [24:0] ir_r;
  cls_t        cls_s;
  logic [2:0]  opc_s;
  logic [2:0]  rx_s;
  logic [2:0]  ry_s;
  logic        rx_in_s;
  logic        rx_out_s;
  logic        ry_out_s;
  logic [15:0] rx_sig_s;
  logic [15:0] ry_sig_s;

  assign opc_s = ir_r[IR_OPC_HI:IR_OPC_LO];
  assign rx_s  = ir_r[IR_RX_HI:IR_RX_LO];
  assign ry_s  = ir_r[IR_RY_HI:IR_RY_LO];
  assign data  = ir_r[IR_IMM_HI:IR_IMM_LO];
  assign state = state_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Instruction register: captured only on an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_r <= 25'd0;
    end else if ((state_r == S_IDLE) && new_func) begin
      ir_r <= func;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Classify the latched opcode into the step pattern it follows
  always_comb begin
    cls_s = C_NOP;
    case (opc_s)
      OPC_ADD, OPC_SUB: cls_s = C_ALU;
`ifdef CONTROL_UNIT_LOGIC_OPS_EN
      OPC_AND, OPC_OR:  cls_s = C_ALU;
`else
      OPC_AND, OPC_OR:  cls_s = C_NOP;
`endif
      OPC_MV:           cls_s = C_MV;
      OPC_MVI:          cls_s = C_MVI;
      default:          cls_s = C_NOP;
    endcase
  end

  // Next-state and Moore control decode
  always_comb begin
    state_next_s = state_r;
    rx_in_s      = 1'b0;
    rx_out_s     = 1'b0;
    ry_out_s     = 1'b0;
    A_in         = 1'b0;
    G_in         = 1'b0;
    G_out        = 1'b0;
    data_in      = 1'b0;
    op           = ALU_ADD;
    case (state_r)
      S_IDLE: begin
        state_next_s = new_func ? S_T1 : S_IDLE;
      end
      S_T1: begin
        case (cls_s)
          C_ALU: begin
            rx_out_s     = 1'b1;
            A_in         = 1'b1;
            state_next_s = S_T2;
          end
          C_MV: begin
            ry_out_s     = 1'b1;
            rx_in_s      = 1'b1;
            state_next_s = S_DONE;
          end
          C_MVI: begin
            data_in      = 1'b1;
            rx_in_s      = 1'b1;
            state_next_s = S_DONE;
          end
          default: begin
            state_next_s = S_DONE;
          end
        endcase
      end
      S_T2: begin
        ry_out_s     = 1'b1;
        G_in         = 1'b1;
        op           = alu_func(opc_s);
        state_next_s = S_T3;
      end
      S_T3: begin
        G_out        = 1'b1;
        rx_in_s      = 1'b1;
        state_next_s = S_DONE;
      end
      S_DONE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  reg_decoder u_rx_dec (
    .idx    (rx_s),
    .en_in  (rx_in_s),
    .en_out (rx_out_s),
    .sig    (rx_sig_s)
  );

  reg_decoder u_ry_dec (
    .idx    (ry_s),
    .en_in  (1'b0),
    .en_out (ry_out_s),
    .sig    (ry_sig_s)
  );

  assign reg_sig = rx_sig_s | ry_sig_s;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a step-list model predicts every
// cycle's outputs, plus directed literal checks on the key sequences.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] func = 25'd0;
  logic        new_func = 1'b0;
  logic [15:0] reg_sig;
  logic        A_in, G_in, G_out, data_in;
  logic [1:0]  op;
  logic [4:0]  state;
  logic [15:0] data;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  control_unit dut (
    .clk(clk), .reset(reset), .func(func), .new_func(new_func),
    .reg_sig(reg_sig), .A_in(A_in), .G_in(G_in), .G_out(G_out),
    .data_in(data_in), .op(op), .state(state), .data(data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  st;
    logic [15:0] rs;
    logic        a, g, go, di;
    logic [1:0]  op;
  } step_t;

  step_t       q[$];
  logic [15:0] mdata = 16'h0000;

  function automatic step_t mk(input logic [4:0] st, input logic [15:0] rs,
                               input logic a, input logic g, input logic go,
                               input logic di, input logic [1:0] o);
    step_t s;
    s.st = st; s.rs = rs; s.a = a; s.g = g; s.go = go; s.di = di; s.op = o;
    return s;
  endfunction

  function automatic logic [15:0] rin(input int r);
    return 16'(32'd1 << (2 * r + 1));
  endfunction

  function automatic logic [15:0] rout(input int r);
    return 16'(32'd1 << (2 * r));
  endfunction

  // Model: queue the whole step list of an instruction when it is accepted
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mdata = 16'h0000;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (new_func) begin
      int opc, rx, ry;
      bit logic_en;
      opc = int'(func[24:22]);
      rx  = int'(func[21:19]);
      ry  = int'(func[18:16]);
      mdata = func[15:0];
`ifdef CONTROL_UNIT_LOGIC_OPS_EN
      logic_en = 1'b1;
`else
      logic_en = 1'b0;
`endif
      if (opc == 0 || opc == 1 || (logic_en && (opc == 4 || opc == 5))) begin
        q.push_back(mk(5'b00010, rout(rx), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        q.push_back(mk(5'b00100, rout(ry), 1'b0, 1'b1, 1'b0, 1'b0,
                       (opc == 0) ? 2'd0 : (opc == 1) ? 2'd1 : (opc == 4) ? 2'd2 : 2'd3));
        q.push_back(mk(5'b01000, rin(rx), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
      end else if (opc == 2) begin
        q.push_back(mk(5'b00010, rout(ry) | rin(rx), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      end else if (opc == 3) begin
        q.push_back(mk(5'b00010, rin(rx), 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
      end else begin
        q.push_back(mk(5'b00010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      end
      q.push_back(mk(5'b10000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare every cycle against the model, away from the rising edge
  always @(negedge clk) begin
    if (cmp_en) begin
      step_t e;
      e = (q.size() > 0) ? q[0] : mk(5'b00001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      check("cycle {state,reg_sig,A,G_in,G_out,data_in,op,data}",
            64'({state, reg_sig, A_in, G_in, G_out, data_in, op, data}),
            64'({e.st, e.rs, e.a, e.g, e.go, e.di, e.op, mdata}));
    end
  end

  // Accept one instruction; returns at the falling edge inside T1
  task automatic start(input logic [24:0] f);
    @(negedge clk);
    func = f;
    new_func = 1'b1;
    @(negedge clk);
    new_func = 1'b0;
    func = 25'h1FFFFFF;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset state", 64'(state), 64'(5'b00001));
    check("reset outputs", 64'({reg_sig, A_in, G_in, G_out, data_in, op, data}), 64'd0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // ADD R1,R0 #000F
    start({3'b000, 3'd1, 3'd0, 16'h000F});
    check("add T1", 64'({state, reg_sig, A_in, data}), 64'({5'b00010, 16'h0004, 1'b1, 16'h000F}));
    @(negedge clk);
    check("add T2", 64'({state, reg_sig, G_in, op}), 64'({5'b00100, 16'h0001, 1'b1, 2'b00}));
    @(negedge clk);
    check("add T3", 64'({state, reg_sig, G_out}), 64'({5'b01000, 16'h0008, 1'b1}));
    @(negedge clk);
    check("add DONE", 64'({state, reg_sig, data}), 64'({5'b10000, 16'h0000, 16'h000F}));
    @(negedge clk);
    check("add IDLE", 64'(state), 64'(5'b00001));

    // MVI R2,#BEEF
    start({3'b011, 3'd2, 3'd0, 16'hBEEF});
    check("mvi T1", 64'({data_in, reg_sig, data}), 64'({1'b1, 16'h0020, 16'hBEEF}));
    repeat (3) @(negedge clk);

    // Busy ignore: SUB offered during T2 of ADD R2,R5
    start({3'b000, 3'd2, 3'd5, 16'h0001});
    @(negedge clk);
    func = {3'b001, 3'd6, 3'd7, 16'h5555};
    new_func = 1'b1;
    check("busy T2 op", 64'({state, op, reg_sig}), 64'({5'b00100, 2'b00, 16'h0400}));
    @(negedge clk);
    new_func = 1'b0;
    check("busy T3", 64'({state, reg_sig, data}), 64'({5'b01000, 16'h0020, 16'h0001}));
    @(negedge clk);
    @(negedge clk);
    check("busy back idle", 64'(state), 64'(5'b00001));

    // Mid-instruction reset during T2 of SUB R3,R4
    start({3'b001, 3'd3, 3'd4, 16'h1111});
    check("sub T1", 64'(reg_sig), 64'(16'h0040));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset state", 64'(state), 64'(5'b00001));
    check("async reset outputs", 64'({reg_sig, A_in, G_in, G_out, data_in, op, data}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after reset quiet", 64'({state, G_out, reg_sig}), 64'({5'b00001, 1'b0, 16'h0000}));
    end

    // Opcode 100: NOP unless logic ops are enabled
    start({3'b100, 3'd1, 3'd2, 16'h1234});
`ifndef CONTROL_UNIT_LOGIC_OPS_EN
    check("and-off T1", 64'({state, reg_sig, A_in, G_in, G_out, data_in, op, data}),
          64'({5'b00010, 16'h0000, 4'b0000, 2'b00, 16'h1234}));
    @(negedge clk);
    check("and-off DONE", 64'({state, op}), 64'({5'b10000, 2'b00}));
    @(negedge clk);
    check("and-off IDLE", 64'(state), 64'(5'b00001));
`else
    repeat (4) @(negedge clk);
`endif

    // OR R4,R1 and NOP 110 / 111 (model-checked)
    start({3'b101, 3'd4, 3'd1, 16'hA5A5});
    repeat (4) @(negedge clk);
    start({3'b110, 3'd7, 3'd7, 16'h00FF});
    repeat (2) @(negedge clk);
    start({3'b111, 3'd0, 3'd3, 16'h0F0F});
    repeat (2) @(negedge clk);

    // MV R3,R3 raises both enables of R3
    start({3'b010, 3'd3, 3'd3, 16'h7777});
    check("mv same reg", 64'(reg_sig), 64'(16'h00C0));
    repeat (2) @(negedge clk);

    // MV R5,R6 with new_func held high: re-accepted at every IDLE edge
    func = {3'b010, 3'd5, 3'd6, 16'hCAFE};
    new_func = 1'b1;
    repeat (7) @(negedge clk);
    new_func = 1'b0;
    repeat (4) @(negedge clk);

    // SUB R7,R0 to finish with a full ALU sequence
    start({3'b001, 3'd7, 3'd0, 16'hFFFF});
    @(negedge clk);
    check("sub T2 op", 64'({op, reg_sig}), 64'({2'b01, 16'h0001}));
    repeat (4) @(negedge clk);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
